mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single unified memory bus port between the IF stage (instruction fetch, read-only) and the MEM stage (load/store). Each requester uses a req/ack handshake; on the bus side the arbiter holds one transaction open until the memory acknowledges it. MEM has priority, with an anti-starvation guard for IF, branch-flush discard of in-flight fetches, and a bus timeout watchdog. Stall outputs feed the pipeline's stall logic.

Parameters:
MAX_MEM_RUN, 4, consecutive MEM grants allowed while IF is waiting before IF is forced through.
TIMEOUT, 255, cycles a bus transaction may stay open without bus_ack_i before it is aborted.

Ports:
clk_i  in  1  clock; all state updates on posedge.
n_rst_i  in  1  synchronous active-low reset.
IF_req_i  in  1  fetch request; held until IF_ack_o.
IF_addr_i  in  32  fetch address.
IF_flush_i  in  1  branch taken; discard any pending or in-flight fetch.
IF_ack_o  out  1  one-cycle fetch completion pulse.
IF_rdata_o  out  32  fetched word; valid while IF_ack_o.
IF_stall_o  out  1  IF_req_i & ~IF_ack_o (combinational).
MEM_req_i  in  1  data request; held until MEM_ack_o.
MEM_we_i  in  1  1 = store, 0 = load.
MEM_size_i  in  2  `WORD/`HALFWORD/`BYTE code, passed through unchanged.
MEM_addr_i  in  32  data address.
MEM_wdata_i  in  32  store data.
MEM_ack_o  out  1  one-cycle data completion pulse.
MEM_rdata_o  out  32  load data; valid while MEM_ack_o.
MEM_stall_o  out  1  MEM_req_i & ~MEM_ack_o (combinational).
bus_req_o  out  1  bus transaction open.
bus_we_o  out  1  write strobe.
bus_size_o  out  2  access size (`WORD for IF).
bus_addr_o  out  32  address.
bus_wdata_o  out  32  write data.
bus_ack_i  in  1  memory completion; only meaningful while bus_req_o is high.
bus_rdata_i  in  32  read data; valid with bus_ack_i.
timeout_o  out  1  sticky bus-timeout error flag.

Behaviour:
- Reset (n_rst_i low at posedge): state IDLE. All outputs 0, including rdata outputs, bus_* outputs and timeout_o. Run counter, timeout counter and discard flag cleared. Any in-flight bus transaction is abandoned; bus_ack_i arriving afterwards in IDLE is ignored.
- States: IDLE, BUSY_IF, BUSY_MEM.
- IDLE eligibility: a requester is eligible if its req is high and its ack_o is low this cycle, so the requester has one cycle to drop or renew req. IF is also ineligible while IF_flush_i is high.
- IDLE grant: MEM wins, unless IF is eligible and run_cnt == MAX_MEM_RUN, in which case IF wins.
- On grant, latch addr/we/size/wdata into the bus_* registers and set bus_req_o = 1 from the next cycle. IF grants use we = 0 and size = `WORD.
- run_cnt: incremented (saturating at MAX_MEM_RUN) on each MEM grant made while IF_req_i is high. Cleared on an IF grant, or when IF_req_i is low in IDLE.
- BUSY_x with bus_ack_i = 1: at the edge, bus_req_o goes to 0 and the state returns to IDLE.
  - Pulse x_ack_o for exactly one cycle.
  - x_rdata_o = bus_rdata_i for reads; 0 for MEM stores.
  - rdata outputs return to 0 when ack_o drops.
- Minimum latency: req seen in IDLE at cycle 0 → bus_req_o high at cycle 1 → bus_ack_i at cycle 1 → ack_o high at cycle 2. Back-to-back grants have one IDLE cycle between transactions.
- Flush: IF_flush_i high while in BUSY_IF, including on the bus_ack_i cycle, sets the discard flag.
  - The transaction still completes on the bus, but IF_ack_o is not pulsed.
  - The discard flag clears on return to IDLE.
  - Flush has no effect on BUSY_MEM.
- Timeout: a counter is cleared at grant and incremented each BUSY cycle without bus_ack_i. On reaching TIMEOUT:
  - bus_req_o drops and the state goes to IDLE.
  - The owner gets ack_o with rdata 0, unless IF has been discarded.
  - timeout_o is set to 1 and stays high until reset.
- bus_* address/data/size are stable for the whole transaction. Changes on requester inputs after the grant are ignored.

Test Plan:
- IF_req_i only, addr 0x100, memory acks 1 cycle after bus_req_o with 0xDEADBEEF → IF_ack_o at cycle 3, IF_rdata_o = 0xDEADBEEF, bus_size_o = `WORD, bus_we_o = 0.
- IF and MEM (store, `BYTE, addr 0x2003, wdata 0xAB) requested in the same cycle → MEM granted first with bus_we_o = 1, bus_size_o = `BYTE; MEM_ack_o with rdata 0; IF granted in the following IDLE; IF_stall_o high throughout.
- MEM_req_i held continuously (ack renewed every transaction) while IF_req_i held → exactly 4 MEM grants, then 1 IF grant, then MEM resumes.
- IF in flight, IF_flush_i pulsed one cycle, bus_ack_i 3 cycles later → no IF_ack_o; arbiter back in IDLE; a new IF request is granted normally.
- bus_ack_i never asserted (TIMEOUT = 255) on a MEM load → MEM_ack_o at grant+256 cycles with rdata 0, timeout_o = 1 and sticky; a late bus_ack_i is ignored.
- n_rst_i low mid BUSY_MEM → next cycle all outputs 0 and state IDLE; bus_ack_i arriving afterwards produces no MEM_ack_o.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory bus port between the instruction-fetch stage (IF,
// read-only) and the load/store stage (MEM). MEM has priority. An IF request
// is forced through after MAX_MEM_RUN consecutive MEM grants made while IF was
// waiting. A taken branch (IF_flush_i) discards a pending or in-flight fetch.
// A watchdog aborts any bus transaction that stays open for TIMEOUT cycles
// and raises a sticky error flag.
//
// Ports
//   clk_i, n_rst_i           clock, synchronous active-low reset
//   IF_req_i/IF_addr_i       fetch request and address (held until IF_ack_o)
//   IF_flush_i               discard any pending or in-flight fetch
//   IF_ack_o/IF_rdata_o      one-cycle fetch completion pulse and word
//   IF_stall_o               IF_req_i & ~IF_ack_o
//   MEM_req_i/we/size/addr/wdata  data request (held until MEM_ack_o)
//   MEM_ack_o/MEM_rdata_o    one-cycle data completion pulse and load data
//   MEM_stall_o              MEM_req_i & ~MEM_ack_o
//   bus_req_o..bus_wdata_o   open bus transaction and its attributes
//   bus_ack_i/bus_rdata_i    memory completion and read data
//   timeout_o                sticky bus-timeout error flag
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MAX_MEM_RUN = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk_i,
    input  logic        n_rst_i,

    input  logic        IF_req_i,
    input  logic [31:0] IF_addr_i,
    input  logic        IF_flush_i,
    output logic        IF_ack_o,
    output logic [31:0] IF_rdata_o,
    output logic        IF_stall_o,

    input  logic        MEM_req_i,
    input  logic        MEM_we_i,
    input  logic [1:0]  MEM_size_i,
    input  logic [31:0] MEM_addr_i,
    input  logic [31:0] MEM_wdata_i,
    output logic        MEM_ack_o,
    output logic [31:0] MEM_rdata_o,
    output logic        MEM_stall_o,

    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [1:0]  bus_size_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,

    output logic        timeout_o
);

    // Size encoding: 2'b00 byte, 2'b01 halfword, 2'b10 word. Fetches are words.
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int RUN_W = $clog2(MAX_MEM_RUN + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic [RUN_W-1:0]  run_cnt_q,   run_cnt_d;
    logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
    logic              discard_q,   discard_d;
    logic              bus_req_q,   bus_req_d;
    logic              bus_we_q,    bus_we_d;
    logic [1:0]        bus_size_q,  bus_size_d;
    logic [31:0]       bus_addr_q,  bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic              if_ack_q,    if_ack_d;
    logic [31:0]       if_rdata_q,  if_rdata_d;
    logic              mem_ack_q,   mem_ack_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              timeout_q,   timeout_d;

    logic              if_elig;
    logic              mem_elig;
    logic              run_at_max;
    logic              to_expired;
    logic              if_keep;

    // A requester whose ack is high this cycle gets one cycle to drop or
    // renew its request before it can be granted again.
    assign if_elig    = IF_req_i & ~if_ack_q & ~IF_flush_i;
    assign mem_elig   = MEM_req_i & ~mem_ack_q;
    assign run_at_max = (run_cnt_q == RUN_W'(MAX_MEM_RUN));
    // The counter holds the number of ack-less BUSY cycles already elapsed;
    // this one is the last allowed before the transaction is aborted.
    assign to_expired = (to_cnt_q == TO_W'(TIMEOUT - 1));
    // Fetch result is delivered unless flushed now or earlier in the transaction.
    assign if_keep    = ~discard_q & ~IF_flush_i;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        to_cnt_d    = to_cnt_q;
        discard_d   = discard_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_size_d  = bus_size_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_ack_d    = 1'b0;
        if_rdata_d  = '0;
        mem_ack_d   = 1'b0;
        mem_rdata_d = '0;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                to_cnt_d  = '0;
                if (!IF_req_i) begin
                    run_cnt_d = '0;
                end

                if (if_elig && (!mem_elig || run_at_max)) begin
                    state_d     = BUSY_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_size_d  = SIZE_WORD;
                    bus_addr_d  = IF_addr_i;
                    bus_wdata_d = '0;
                    run_cnt_d   = '0;
                end else if (mem_elig) begin
                    state_d     = BUSY_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = MEM_we_i;
                    bus_size_d  = MEM_size_i;
                    bus_addr_d  = MEM_addr_i;
                    bus_wdata_d = MEM_wdata_i;
                    // Count MEM grants that overtake a waiting fetch.
                    if (IF_req_i && !run_at_max) begin
                        run_cnt_d = run_cnt_q + 1'b1;
                    end
                end
            end

            BUSY_IF, BUSY_MEM: begin
                if (bus_ack_i || to_expired) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    discard_d = 1'b0;
                    to_cnt_d  = '0;
                    if (!bus_ack_i) begin
                        timeout_d = 1'b1;
                    end
                    // An aborted transaction completes with rdata 0; a store
                    // returns 0 as well.
                    if (state_q == BUSY_IF) begin
                        if_ack_d   = if_keep;
                        if_rdata_d = (bus_ack_i && if_keep) ? bus_rdata_i : '0;
                    end else begin
                        mem_ack_d   = 1'b1;
                        mem_rdata_d = (bus_ack_i && !bus_we_q) ? bus_rdata_i : '0;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (state_q == BUSY_IF && IF_flush_i) begin
                        discard_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values computed before this edge, independent of order.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous: it takes effect only at a clock edge
        // where n_rst_i is low, and clears every register including the
        // output data registers.
        if (!n_rst_i) begin
            state_q     <= IDLE;
            run_cnt_q   <= '0;
            to_cnt_q    <= '0;
            discard_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_size_q  <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_ack_q   <= 1'b0;
            mem_rdata_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            to_cnt_q    <= to_cnt_d;
            discard_q   <= discard_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_size_q  <= bus_size_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_ack_q   <= mem_ack_d;
            mem_rdata_q <= mem_rdata_d;
            timeout_q   <= timeout_d;
        end
    end

    assign IF_ack_o    = if_ack_q;
    assign IF_rdata_o  = if_rdata_q;
    assign IF_stall_o  = IF_req_i & ~if_ack_q;
    assign MEM_ack_o   = mem_ack_q;
    assign MEM_rdata_o = mem_rdata_q;
    assign MEM_stall_o = MEM_req_i & ~mem_ack_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_size_o  = bus_size_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (MAX_MEM_RUN = 4, TIMEOUT = 255).
// Inputs are driven 1 ns after the rising edge and outputs are compared
// 1 ns later, so each comparison sees one settled clock cycle.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic        clk_i;
    logic        n_rst_i;
    logic        IF_req_i;
    logic [31:0] IF_addr_i;
    logic        IF_flush_i;
    logic        IF_ack_o;
    logic [31:0] IF_rdata_o;
    logic        IF_stall_o;
    logic        MEM_req_i;
    logic        MEM_we_i;
    logic [1:0]  MEM_size_i;
    logic [31:0] MEM_addr_i;
    logic [31:0] MEM_wdata_i;
    logic        MEM_ack_o;
    logic [31:0] MEM_rdata_o;
    logic        MEM_stall_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [1:0]  bus_size_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.MAX_MEM_RUN(4), .TIMEOUT(255)) dut (
        .clk_i       (clk_i),
        .n_rst_i     (n_rst_i),
        .IF_req_i    (IF_req_i),
        .IF_addr_i   (IF_addr_i),
        .IF_flush_i  (IF_flush_i),
        .IF_ack_o    (IF_ack_o),
        .IF_rdata_o  (IF_rdata_o),
        .IF_stall_o  (IF_stall_o),
        .MEM_req_i   (MEM_req_i),
        .MEM_we_i    (MEM_we_i),
        .MEM_size_i  (MEM_size_i),
        .MEM_addr_i  (MEM_addr_i),
        .MEM_wdata_i (MEM_wdata_i),
        .MEM_ack_o   (MEM_ack_o),
        .MEM_rdata_o (MEM_rdata_o),
        .MEM_stall_o (MEM_stall_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_size_o  (bus_size_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .timeout_o   (timeout_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // One cycle-snapshot: inputs for the cycle and the outputs expected in it.
    typedef struct {
        logic        if_req;
        logic        if_flush;
        logic [31:0] if_addr;
        logic        mem_req;
        logic        mem_we;
        logic [1:0]  mem_size;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        bus_ack;
        logic [31:0] bus_rdata;
        logic        e_if_ack;
        logic [31:0] e_if_rdata;
        logic        e_mem_ack;
        logic [31:0] e_mem_rdata;
        logic        e_bus_req;
        logic        e_bus_we;
        logic [1:0]  e_bus_size;
        logic [31:0] e_bus_addr;
        logic [31:0] e_bus_wdata;
        logic        e_if_stall;
        logic        e_mem_stall;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        IF_req_i    = 1'b0;
        IF_addr_i   = '0;
        IF_flush_i  = 1'b0;
        MEM_req_i   = 1'b0;
        MEM_we_i    = 1'b0;
        MEM_size_i  = '0;
        MEM_addr_i  = '0;
        MEM_wdata_i = '0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " bus_req"},   {31'd0, bus_req_o},   32'd0);
        check({tag, " bus_we"},    {31'd0, bus_we_o},    32'd0);
        check({tag, " bus_size"},  {30'd0, bus_size_o},  32'd0);
        check({tag, " bus_addr"},  bus_addr_o,           32'd0);
        check({tag, " bus_wdata"}, bus_wdata_o,          32'd0);
        check({tag, " if_ack"},    {31'd0, IF_ack_o},    32'd0);
        check({tag, " if_rdata"},  IF_rdata_o,           32'd0);
        check({tag, " mem_ack"},   {31'd0, MEM_ack_o},   32'd0);
        check({tag, " mem_rdata"}, MEM_rdata_o,          32'd0);
        check({tag, " if_stall"},  {31'd0, IF_stall_o},  32'd0);
        check({tag, " mem_stall"}, {31'd0, MEM_stall_o}, 32'd0);
        check({tag, " timeout"},   {31'd0, timeout_o},   32'd0);
    endtask

    initial begin
        // ---- vector table -------------------------------------------------
        // if_req flush if_addr | mem_req we size addr wdata | ack rdata |
        // e_if_ack e_if_rdata e_mem_ack e_mem_rdata e_bus_req we size addr wdata | e_if_stall e_mem_stall
        // Fetch of 0x100, memory acks one cycle after bus_req_o.
        vecs[0]  = '{1,0,32'h100, 0,0,2'd0,32'h0,32'h0,    0,32'h0,
                     0,32'h0,        0,32'h0, 0,0,2'd0,   32'h0,   32'h0,  1,0};
        vecs[1]  = '{1,0,32'h100, 0,0,2'd0,32'h0,32'h0,    0,32'h0,
                     0,32'h0,        0,32'h0, 1,0,SZ_WORD,32'h100, 32'h0,  1,0};
        vecs[2]  = '{1,0,32'h100, 0,0,2'd0,32'h0,32'h0,    1,32'hDEADBEEF,
                     0,32'h0,        0,32'h0, 1,0,SZ_WORD,32'h100, 32'h0,  1,0};
        vecs[3]  = '{1,0,32'h100, 0,0,2'd0,32'h0,32'h0,    0,32'h0,
                     1,32'hDEADBEEF, 0,32'h0, 0,0,2'd0,   32'h0,   32'h0,  0,0};
        vecs[4]  = '{0,0,32'h100, 0,0,2'd0,32'h0,32'h0,    0,32'h0,
                     0,32'h0,        0,32'h0, 0,0,2'd0,   32'h0,   32'h0,  0,0};
        // IF (0x400) and MEM byte store (0x2003, 0xAB) in the same cycle.
        vecs[5]  = '{1,0,32'h400, 1,1,SZ_BYTE,32'h2003,32'hAB, 0,32'h0,
                     0,32'h0,        0,32'h0, 0,0,2'd0,   32'h0,   32'h0,  1,1};
        vecs[6]  = '{1,0,32'h400, 1,1,SZ_BYTE,32'h2003,32'hAB, 1,32'h12345678,
                     0,32'h0,        0,32'h0, 1,1,SZ_BYTE,32'h2003,32'hAB, 1,1};
        vecs[7]  = '{1,0,32'h400, 1,1,SZ_BYTE,32'h2003,32'hAB, 0,32'h0,
                     0,32'h0,        1,32'h0, 0,0,2'd0,   32'h0,   32'h0,  1,0};
        vecs[8]  = '{1,0,32'h400, 0,0,2'd0,32'h0,32'h0,    1,32'hCAFEF00D,
                     0,32'h0,        0,32'h0, 1,0,SZ_WORD,32'h400, 32'h0,  1,0};
        vecs[9]  = '{1,0,32'h400, 0,0,2'd0,32'h0,32'h0,    0,32'h0,
                     1,32'hCAFEF00D, 0,32'h0, 0,0,2'd0,   32'h0,   32'h0,  0,0};
        vecs[10] = '{0,0,32'h400, 0,0,2'd0,32'h0,32'h0,    0,32'h0,
                     0,32'h0,        0,32'h0, 0,0,2'd0,   32'h0,   32'h0,  0,0};

        // ---- reset state --------------------------------------------------
        idle_inputs();
        n_rst_i = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        n_rst_i = 1'b1;
        tick();

        // ---- table-driven: single fetch, MEM-vs-IF contention ---------------
        for (int i = 0; i < 11; i++) begin
            IF_req_i    = vecs[i].if_req;
            IF_flush_i  = vecs[i].if_flush;
            IF_addr_i   = vecs[i].if_addr;
            MEM_req_i   = vecs[i].mem_req;
            MEM_we_i    = vecs[i].mem_we;
            MEM_size_i  = vecs[i].mem_size;
            MEM_addr_i  = vecs[i].mem_addr;
            MEM_wdata_i = vecs[i].mem_wdata;
            bus_ack_i   = vecs[i].bus_ack;
            bus_rdata_i = vecs[i].bus_rdata;
            #1;
            check($sformatf("vec%0d if_ack", i),    {31'd0, IF_ack_o},    {31'd0, vecs[i].e_if_ack});
            check($sformatf("vec%0d if_rdata", i),  IF_rdata_o,           vecs[i].e_if_rdata);
            check($sformatf("vec%0d mem_ack", i),   {31'd0, MEM_ack_o},   {31'd0, vecs[i].e_mem_ack});
            check($sformatf("vec%0d mem_rdata", i), MEM_rdata_o,          vecs[i].e_mem_rdata);
            check($sformatf("vec%0d bus_req", i),   {31'd0, bus_req_o},   {31'd0, vecs[i].e_bus_req});
            check($sformatf("vec%0d if_stall", i),  {31'd0, IF_stall_o},  {31'd0, vecs[i].e_if_stall});
            check($sformatf("vec%0d mem_stall", i), {31'd0, MEM_stall_o}, {31'd0, vecs[i].e_mem_stall});
            if (vecs[i].e_bus_req) begin
                check($sformatf("vec%0d bus_we", i),   {31'd0, bus_we_o},   {31'd0, vecs[i].e_bus_we});
                check($sformatf("vec%0d bus_size", i), {30'd0, bus_size_o}, {30'd0, vecs[i].e_bus_size});
                check($sformatf("vec%0d bus_addr", i), bus_addr_o,          vecs[i].e_bus_addr);
                if (vecs[i].e_bus_we) begin
                    check($sformatf("vec%0d bus_wdata", i), bus_wdata_o, vecs[i].e_bus_wdata);
                end
            end
            tick();
        end

        // ---- anti-starvation ------------------------------------------------
        // Memory acks at minimum latency throughout. MEM (load 0x600) and IF
        // (0x500) are both held. IF is flushed in each MEM ack cycle so it
        // cannot take that free slot; MEM therefore wins four times, then the
        // run counter forces IF through, then MEM resumes.
        idle_inputs();
        IF_addr_i  = 32'h500;
        MEM_addr_i = 32'h600;
        MEM_size_i = SZ_WORD;
        bus_ack_i  = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            logic       e_req;
            logic       e_mack;
            logic       e_iack;
            IF_req_i    = (c <= 14);
            IF_flush_i  = (c == 2 || c == 5 || c == 8 || c == 11);
            MEM_req_i   = 1'b1;
            bus_rdata_i = 32'h1000 + c;
            #1;
            e_req  = (c == 1 || c == 4 || c == 7 || c == 10 || c == 13 || c == 15);
            e_mack = (c == 2 || c == 5 || c == 8 || c == 11 || c == 16);
            e_iack = (c == 14);
            check($sformatf("run c%0d bus_req", c), {31'd0, bus_req_o}, {31'd0, e_req});
            check($sformatf("run c%0d mem_ack", c), {31'd0, MEM_ack_o}, {31'd0, e_mack});
            check($sformatf("run c%0d if_ack", c),  {31'd0, IF_ack_o},  {31'd0, e_iack});
            if (e_req) begin
                check($sformatf("run c%0d bus_addr", c), bus_addr_o, (c == 13) ? 32'h500 : 32'h600);
            end
            if (e_mack) begin
                check($sformatf("run c%0d mem_rdata", c), MEM_rdata_o, 32'h1000 + c - 1);
            end
            if (e_iack) begin
                check($sformatf("run c%0d if_rdata", c), IF_rdata_o, 32'h1000 + 13);
            end
            tick();
        end
        idle_inputs();
        tick();

        // ---- flush of an in-flight fetch -----------------------------------
        IF_req_i  = 1'b1;                     // c0: grant 0x700
        IF_addr_i = 32'h700;
        tick();
        IF_req_i   = 1'b0;                    // c1: flush while BUSY_IF
        IF_flush_i = 1'b1;
        #1;
        check("flush bus_req open", {31'd0, bus_req_o}, 32'd1);
        check("flush bus_addr", bus_addr_o, 32'h700);
        tick();
        IF_flush_i = 1'b0;                    // c2, c3: still waiting
        tick();
        tick();
        bus_ack_i   = 1'b1;                   // c4: memory completes
        bus_rdata_i = 32'h55;
        #1;
        check("flush bus_req before ack", {31'd0, bus_req_o}, 32'd1);
        tick();
        bus_ack_i = 1'b0;                     // c5: back in IDLE, no ack
        IF_req_i  = 1'b1;
        IF_addr_i = 32'h704;
        #1;
        check("flush discarded if_ack", {31'd0, IF_ack_o}, 32'd0);
        check("flush discarded if_rdata", IF_rdata_o, 32'd0);
        check("flush bus_req closed", {31'd0, bus_req_o}, 32'd0);
        tick();
        bus_ack_i   = 1'b1;                   // c6: new fetch on the bus
        bus_rdata_i = 32'h11112222;
        #1;
        check("refetch bus_addr", bus_addr_o, 32'h704);
        check("refetch bus_req", {31'd0, bus_req_o}, 32'd1);
        tick();
        bus_ack_i = 1'b0;                     // c7: normal completion
        #1;
        check("refetch if_ack", {31'd0, IF_ack_o}, 32'd1);
        check("refetch if_rdata", IF_rdata_o, 32'h11112222);
        tick();
        IF_req_i = 1'b0;                      // c8
        tick();
        // Flush asserted in the very cycle the memory acks.
        IF_req_i  = 1'b1;                     // c9: grant 0x708
        IF_addr_i = 32'h708;
        tick();
        IF_req_i    = 1'b0;                   // c10: ack and flush together
        IF_flush_i  = 1'b1;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h77;
        tick();
        IF_flush_i = 1'b0;                    // c11
        bus_ack_i  = 1'b0;
        #1;
        check("flush-on-ack if_ack", {31'd0, IF_ack_o}, 32'd0);
        check("flush-on-ack bus_req", {31'd0, bus_req_o}, 32'd0);
        tick();

        // ---- bus timeout on a MEM load -------------------------------------
        idle_inputs();
        MEM_req_i   = 1'b1;
        MEM_addr_i  = 32'h800;
        MEM_size_i  = SZ_WORD;
        bus_rdata_i = 32'hFFFF_FFFF;
        #1;
        check("timeout clear before", {31'd0, timeout_o}, 32'd0);
        tick();                                // now at grant + 1
        for (int c = 1; c <= 256; c++) begin
            check($sformatf("to c%0d bus_req", c), {31'd0, bus_req_o}, {31'd0, (c <= 255)});
            check($sformatf("to c%0d mem_ack", c), {31'd0, MEM_ack_o}, {31'd0, (c == 256)});
            if (c == 255 || c == 256) begin
                check($sformatf("to c%0d timeout", c), {31'd0, timeout_o}, {31'd0, (c == 256)});
            end
            if (c == 256) begin
                check("to mem_rdata", MEM_rdata_o, 32'd0);
            end
            tick();
        end
        MEM_req_i = 1'b0;                     // grant + 257: late ack
        bus_ack_i = 1'b1;
        #1;
        check("to sticky a", {31'd0, timeout_o}, 32'd1);
        check("to mem_ack dropped", {31'd0, MEM_ack_o}, 32'd0);
        tick();
        bus_ack_i = 1'b0;
        #1;
        check("late ack ignored mem_ack", {31'd0, MEM_ack_o}, 32'd0);
        check("late ack ignored bus_req", {31'd0, bus_req_o}, 32'd0);
        check("to sticky b", {31'd0, timeout_o}, 32'd1);
        tick();

        // ---- reset in the middle of BUSY_MEM -------------------------------
        MEM_req_i   = 1'b1;                   // c0: grant a byte load
        MEM_addr_i  = 32'h900;
        MEM_size_i  = SZ_BYTE;
        MEM_wdata_i = 32'hAA;
        tick();
        #1;                                   // c1: transaction open
        check("rst pre bus_req", {31'd0, bus_req_o}, 32'd1);
        check("rst pre bus_addr", bus_addr_o, 32'h900);
        tick();
        n_rst_i   = 1'b0;                     // c2: reset sampled at next edge
        MEM_req_i = 1'b0;
        tick();
        n_rst_i   = 1'b1;                     // c3: everything cleared
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h3333_4444;
        #1;
        check_all_zero("midrst");
        tick();
        check("post-rst mem_ack a", {31'd0, MEM_ack_o}, 32'd0);
        check("post-rst bus_req a", {31'd0, bus_req_o}, 32'd0);
        tick();
        bus_ack_i = 1'b0;
        check("post-rst mem_ack b", {31'd0, MEM_ack_o}, 32'd0);
        check("post-rst mem_rdata", MEM_rdata_o, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
